// File: rtl/packet_stats_no_ready.sv
// Per-packet beat count, sum, min and max over a valid/last stream.
// Latency: record is registered, down_valid pulses 1 cycle after the last beat is sampled.
// Backpressure: none; each record is presented for exactly one cycle and must be captured.
module packet_stats_no_ready #(
   parameter int width     = 8,
   parameter int len_width = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         up_valid,
   input  logic                         up_last,
   input  logic [width-1:0]             up_data,
   output logic                         down_valid,
   output logic [len_width-1:0]         down_len,
   output logic [width+len_width-1:0]   down_sum,
   output logic [width-1:0]             down_min,
   output logic [width-1:0]             down_max,
   output logic                         down_ovf
);

   localparam int SUM_W = width + len_width;
   localparam logic [len_width-1:0] LEN_ONE = len_width'(1);

   // IDLE: no packet open, next valid beat seeds the stats.
   // ACTIVE: a packet is open, beats fold into the accumulators.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [len_width-1:0]  r_acc_len;
   logic [SUM_W-1:0]      r_acc_sum;
   logic [width-1:0]      r_acc_min;
   logic [width-1:0]      r_acc_max;
   logic                  r_acc_ovf;

   logic                  r_down_valid;
   logic [len_width-1:0]  r_down_len;
   logic [SUM_W-1:0]      r_down_sum;
   logic [width-1:0]      r_down_min;
   logic [width-1:0]      r_down_max;
   logic                  r_down_ovf;

   // Effective stats: the accumulators with the current beat already folded in.
   logic [len_width-1:0]  w_eff_len;
   logic [SUM_W-1:0]      w_eff_sum;
   logic [width-1:0]      w_eff_min;
   logic [width-1:0]      w_eff_max;
   logic                  w_eff_ovf;

   logic [SUM_W-1:0]      w_data_ext;
   logic                  w_len_full;
   logic                  w_beat_mid;
   logic                  w_beat_last;

   assign w_data_ext  = {{len_width{1'b0}}, up_data};
   assign w_len_full  = &r_acc_len;
   assign w_beat_mid  = up_valid & ~up_last;
   assign w_beat_last = up_valid & up_last;

   // State register for the packet-open flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and the effective stats for the beat on the bus this cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_eff_len   = LEN_ONE;
      w_eff_sum   = w_data_ext;
      w_eff_min   = up_data;
      w_eff_max   = up_data;
      w_eff_ovf   = 1'b0;

      if (w_beat_mid) begin
         w_state_nxt = ACTIVE;
      end else if (w_beat_last) begin
         w_state_nxt = IDLE;
      end

      case (r_state)
         IDLE: begin
            // Seed values already assigned above.
         end
         ACTIVE: begin
            // Length sticks at all-ones once it would wrap, and flags overflow.
            if (w_len_full) begin
               w_eff_len = r_acc_len;
               w_eff_ovf = 1'b1;
            end else begin
               w_eff_len = r_acc_len + LEN_ONE;
               w_eff_ovf = r_acc_ovf;
            end
            w_eff_sum = r_acc_sum + w_data_ext;
            w_eff_min = (up_data < r_acc_min) ? up_data : r_acc_min;
            w_eff_max = (up_data > r_acc_max) ? up_data : r_acc_max;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Accumulators: load on a middle beat, clear on a last beat, hold on idle cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc_len <= '0;
         r_acc_sum <= '0;
         r_acc_min <= '0;
         r_acc_max <= '0;
         r_acc_ovf <= 1'b0;
      end else if (w_beat_last) begin
         r_acc_len <= '0;
         r_acc_sum <= '0;
         r_acc_min <= '0;
         r_acc_max <= '0;
         r_acc_ovf <= 1'b0;
      end else if (w_beat_mid) begin
         r_acc_len <= w_eff_len;
         r_acc_sum <= w_eff_sum;
         r_acc_min <= w_eff_min;
         r_acc_max <= w_eff_max;
         r_acc_ovf <= w_eff_ovf;
      end
   end

   // One-cycle record strobe following each sampled last beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_down_valid <= 1'b0;
      end else begin
         r_down_valid <= w_beat_last;
      end
   end

   // Record fields capture the final stats and hold them until the next record.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_down_len <= '0;
         r_down_sum <= '0;
         r_down_min <= '0;
         r_down_max <= '0;
         r_down_ovf <= 1'b0;
      end else if (w_beat_last) begin
         r_down_len <= w_eff_len;
         r_down_sum <= w_eff_sum;
         r_down_min <= w_eff_min;
         r_down_max <= w_eff_max;
         r_down_ovf <= w_eff_ovf;
      end
   end

   assign down_valid = r_down_valid;
   assign down_len   = r_down_len;
   assign down_sum   = r_down_sum;
   assign down_min   = r_down_min;
   assign down_max   = r_down_max;
   assign down_ovf   = r_down_ovf;

endmodule

// File: tb/tb_packet_stats_no_ready.sv
// Scoreboard bench for packet_stats_no_ready (width=8, len_width=8).
// Stimulus pushes hand-computed records with the cycle they must appear on.
// A monitor pops and compares each down_valid pulse; extra pulses are flagged.
module tb_packet_stats_no_ready;

   logic         clock;
   logic         reset;
   logic         up_valid;
   logic         up_last;
   logic [7:0]   up_data;
   logic         down_valid;
   logic [7:0]   down_len;
   logic [15:0]  down_sum;
   logic [7:0]   down_min;
   logic [7:0]   down_max;
   logic         down_ovf;

   typedef struct {
      logic [7:0]  len;
      logic [15:0] sum;
      logic [7:0]  mn;
      logic [7:0]  mx;
      logic        ovf;
      int          cyc;
   } rec_t;

   rec_t q[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_fail = 0;

   packet_stats_no_ready #(.width(8), .len_width(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .up_valid   (up_valid),
      .up_last    (up_last),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_len   (down_len),
      .down_sum   (down_sum),
      .down_min   (down_min),
      .down_max   (down_max),
      .down_ovf   (down_ovf)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Expected record appears after the next clock edge.
   task automatic push(input logic [7:0] len, input logic [15:0] sum,
                       input logic [7:0] mn, input logic [7:0] mx, input logic ovf);
      rec_t r;
      r.len = len; r.sum = sum; r.mn = mn; r.mx = mx; r.ovf = ovf;
      r.cyc = cyc + 1;
      q.push_back(r);
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      up_valid = 1'b1;
      up_data  = d;
      up_last  = l;
      @(posedge clock);
      #1;
      up_valid = 1'b0;
      up_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk_zero(input string tag);
      @(negedge clock);
      chk({tag, "_valid"}, down_valid, 0);
      chk({tag, "_len"},   down_len,   0);
      chk({tag, "_sum"},   down_sum,   0);
      chk({tag, "_min"},   down_min,   0);
      chk({tag, "_max"},   down_max,   0);
      chk({tag, "_ovf"},   down_ovf,   0);
   endtask

   // Monitor: every down_valid pulse must match the oldest expected record.
   initial begin
      rec_t e;
      forever begin
         @(negedge clock);
         if (down_valid === 1'b1) begin
            if (q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_valid: got down_valid=1 at cycle %0d required no record", cyc);
            end else begin
               e = q.pop_front();
               chk("rec_cycle", cyc,      e.cyc);
               chk("rec_len",   down_len, e.len);
               chk("rec_sum",   down_sum, e.sum);
               chk("rec_min",   down_min, e.mn);
               chk("rec_max",   down_max, e.mx);
               chk("rec_ovf",   down_ovf, e.ovf);
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      up_valid = 1'b0;
      up_last  = 1'b0;
      up_data  = 8'h00;
      idle(2);
      reset = 1'b0;
      chk_zero("reset");

      // Single beat, then fields must hold with valid low.
      push(8'd1, 16'h005A, 8'h5A, 8'h5A, 1'b0);
      beat(8'h5A, 1'b1);
      idle(1);
      @(negedge clock);
      chk("hold_valid", down_valid, 0);
      chk("hold_len",   down_len,   1);
      chk("hold_sum",   down_sum,   16'h005A);
      chk("hold_min",   down_min,   8'h5A);
      chk("hold_max",   down_max,   8'h5A);

      // Gapped packet 3, 250, 7.
      beat(8'd3, 1'b0);
      idle(2);
      beat(8'd250, 1'b0);
      idle(1);
      push(8'd3, 16'd260, 8'd3, 8'd250, 1'b0);
      beat(8'd7, 1'b1);
      idle(3);

      // Back-to-back {1,2} then {9}, then two single-beat packets on consecutive cycles.
      beat(8'd1, 1'b0);
      push(8'd2, 16'd3, 8'd1, 8'd2, 1'b0);
      beat(8'd2, 1'b1);
      push(8'd1, 16'd9, 8'd9, 8'd9, 1'b0);
      beat(8'd9, 1'b1);
      push(8'd1, 16'h0011, 8'h11, 8'h11, 1'b0);
      beat(8'h11, 1'b1);
      push(8'd1, 16'h0022, 8'h22, 8'h22, 1'b0);
      beat(8'h22, 1'b1);
      idle(2);

      // 300 beats of 0xFF: length saturates at 255, sum keeps counting.
      for (int i = 0; i < 300; i++) begin
         if (i == 299) push(8'd255, 16'((300 * 255) % 65536), 8'hFF, 8'hFF, 1'b1);
         beat(8'hFF, i == 299);
      end
      idle(1);
      push(8'd1, 16'd4, 8'd4, 8'd4, 1'b0);
      beat(8'd4, 1'b1);
      idle(2);

      // Exactly 255 beats 0..254: largest length without overflow.
      for (int i = 0; i < 255; i++) begin
         if (i == 254) push(8'd255, 16'd32385, 8'd0, 8'd254, 1'b0);
         beat(8'(i), i == 254);
      end
      idle(2);

      // Reset mid-packet discards the partial packet.
      beat(8'd10, 1'b0);
      beat(8'd20, 1'b0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      chk_zero("midrst");
      push(8'd1, 16'd5, 8'd5, 8'd5, 1'b0);
      beat(8'd5, 1'b1);
      idle(2);

      // Reset on the same edge as a last beat: no record, outputs cleared.
      up_valid = 1'b1;
      up_data  = 8'h77;
      up_last  = 1'b1;
      reset    = 1'b1;
      @(posedge clock);
      #1;
      reset    = 1'b0;
      up_valid = 1'b0;
      up_last  = 1'b0;
      chk_zero("collide");
      idle(4);

      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
